// File: rtl/sum_tx_ctrl.sv
// sum_tx_ctrl: debounced operand capture, registered 5-bit sum and a busy-handshake UART frame sequencer.
// Define SUM_TX_ASCII_EN for a 4-byte ASCII hex frame (sum[4], sum[3:0], CR, LF); otherwise one raw byte.

module sum_tx_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACCEPT_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       save_a_n,
    input  logic       save_b_n,
    input  logic [3:0] data_input,
    input  logic       send_req,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [4:0] sum,
    output logic       ctrl_busy,
    output logic       tx_error
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int TO_W = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [DB_W-1:0] DB_FIRE = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_SAT  = DB_W'(DEBOUNCE_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACCEPT_TIMEOUT - 1);
`ifdef SUM_TX_ASCII_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    logic [SYNC_STAGES-1:0]      r_sync_a;
    logic [SYNC_STAGES-1:0]      r_sync_b;
    logic [SYNC_STAGES-1:0][3:0] r_sync_d;
    logic [DB_W-1:0]             r_db_a;
    logic [DB_W-1:0]             r_db_b;
    logic [3:0]                  r_op_a;
    logic [3:0]                  r_op_b;
    logic [4:0]                  r_sum;
    logic                        r_pending;
    state_t                      r_state;
    logic [4:0]                  r_frame;
    logic [1:0]                  r_idx;
    logic [TO_W-1:0]             r_timer;
    logic [7:0]                  r_tx_data;
    logic                        r_tx_error;

    logic       w_low_a;
    logic       w_low_b;
    logic       w_stb_a;
    logic       w_stb_b;
    logic [4:0] w_sum_next;
    state_t     w_state_next;
    logic [4:0] w_frame_next;
    logic [1:0] w_idx_next;
    logic       w_timeout;
    logic [7:0] w_byte;

    // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_a <= '1;
            r_sync_b <= '1;
            r_sync_d <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], save_a_n};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], save_b_n};
            r_sync_d <= {r_sync_d[SYNC_STAGES-2:0], data_input};
        end
    end

    assign w_low_a = ~r_sync_a[SYNC_STAGES-1];
    assign w_low_b = ~r_sync_b[SYNC_STAGES-1];
    assign w_stb_a = w_low_a && (r_db_a == DB_FIRE);
    assign w_stb_b = w_low_b && (r_db_b == DB_FIRE);

    // Counters park one past the fire value, so a held button strobes exactly once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_a <= '0;
            r_db_b <= '0;
        end else begin
            if (!w_low_a)              r_db_a <= '0;
            else if (r_db_a != DB_SAT) r_db_a <= r_db_a + DB_W'(1);
            if (!w_low_b)              r_db_b <= '0;
            else if (r_db_b != DB_SAT) r_db_b <= r_db_b + DB_W'(1);
        end
    end

    assign w_sum_next = {1'b0, r_op_a} + {1'b0, r_op_b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_sum     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_stb_a) r_op_a <= r_sync_d[SYNC_STAGES-1];
            if (w_stb_b) r_op_b <= r_sync_d[SYNC_STAGES-1];
            r_sum     <= w_sum_next;
            r_pending <= w_stb_b | send_req | (r_pending & ~((r_state == S_IDLE) & r_pending));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame;
        w_idx_next   = r_idx;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    // Same value r_sum takes this edge, so the frame carries the freshly captured operands.
                    w_frame_next = w_sum_next;
                    w_idx_next   = 2'd0;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD:        w_state_next = S_WAIT_ACCEPT;
            S_WAIT_ACCEPT: begin
                if (uart_tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_timer == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE:   if (!uart_tx_busy) w_state_next = S_NEXT;
            S_NEXT: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_idx_next   = r_idx + 2'd1;
                    w_state_next = S_LOAD;
                end
            end
            default:       w_state_next = S_IDLE;
        endcase
    end

`ifdef SUM_TX_ASCII_EN
    always_comb begin
        w_byte = 8'h0A;
        case (w_idx_next)
            2'd0:    w_byte = {7'b0011000, w_frame_next[4]};
            2'd1:    w_byte = (w_frame_next[3:0] < 4'd10) ? 8'h30 + {4'h0, w_frame_next[3:0]}
                                                          : 8'h37 + {4'h0, w_frame_next[3:0]};
            2'd2:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end
`else
    assign w_byte = {3'b000, w_frame_next};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame    <= '0;
            r_idx      <= '0;
            r_timer    <= '0;
            r_tx_data  <= '0;
            r_tx_error <= 1'b0;
        end else begin
            r_frame <= w_frame_next;
            r_idx   <= w_idx_next;
            if (r_state == S_LOAD)             r_timer <= '0;
            else if (r_state == S_WAIT_ACCEPT) r_timer <= r_timer + TO_W'(1);
            if (w_state_next == S_LOAD)        r_tx_data <= w_byte;
            if (w_timeout)                     r_tx_error <= 1'b1;
        end
    end

    assign uart_tx_en   = (r_state == S_LOAD);
    assign uart_tx_data = r_tx_data;
    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign sum          = r_sum;
    assign ctrl_busy    = (r_state != S_IDLE);
    assign tx_error     = r_tx_error;

endmodule
